fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction sequencer for the CPU. Owns the instruction pointer (IP), drives the
//  line memory, and latches the fetched line into an instruction register. Issues
//  each instruction to the datapath with a valid/done handshake, then resolves the
//  next IP (sequential, jump, or taken beq). Stops on the halt word or on an
//  out-of-range IP.
// PARAMETERS
//  IP_WIDTH    IP_WIDTH (params.svh)    width of instruction pointer
//  LINE_WIDTH  LINE_WIDTH (params.svh)  instruction word width (32)
//  NUM_LINES   NUM_LINES (params.svh)   index of the halt slot; highest legal IP
//  CNT_WIDTH   16                       width of retired-instruction counter
// PORTS
//  clk          in   1           system clock, rising edge
//  nrst         in   1           asynchronous reset, active-low
//  start        in   1           1-cycle pulse; begin execution at IP 0
//  mem_en       out  1           line memory enable, high only in FETCH
//  ip           out  IP_WIDTH    address to line memory
//  line         in   LINE_WIDTH  combinational read data from line memory
//  instr        out  LINE_WIDTH  latched instruction to datapath
//  instr_valid  out  1           instr is valid and awaiting execution
//  exec_done    in   1           datapath finished instr (sampled only when instr_valid=1)
//  cmp_eq       in   1           datapath equality result for beq, valid with exec_done
//  running      out  1           high in FETCH or ISSUE
//  halted       out  1           high in HALT
//  fault        out  1           sticky: IP left range [0, NUM_LINES]
//  retired      out  CNT_WIDTH   count of completed instructions, saturating
// BEHAVIOUR
//  Reset (async, nrst=0): state=IDLE, ip=0, instr=0, all flags 0, retired=0.
//  Fields: op=instr[31:24], tgt=instr[23:16]; HALT_WORD=32'hFFFFFFFF.
//  States:
//   IDLE:  outputs quiet. start=1 -> FETCH with ip=0, retired=0, fault=0.
//   FETCH: mem_en=1. At clock edge:
//     line==HALT_WORD -> HALT, instr not updated.
//     otherwise       -> instr<=line, go to ISSUE.
//   ISSUE: instr_valid=1; hold until exec_done=1. On that edge, retired+=1
//     (saturate at all-ones) and next IP is:
//       op==OP_JMP             -> tgt
//       op==OP_BEQ & cmp_eq    -> tgt
//       any other case         -> ip+1
//     Unknown opcodes are passed to the datapath unchanged and advance by ip+1.
//     If next IP > NUM_LINES: fault<=1, go to HALT, ip keeps the last legal value.
//     Otherwise: ip<=next IP, go to FETCH.
//   HALT: halted=1. start=1 -> FETCH at ip=0; this also clears fault and retired.
//  Latency: start to first instr_valid = 2 cycles. Minimum 2 cycles per instruction
//   (FETCH + ISSUE with same-cycle exec_done).
//  IP width: ip+1 is computed at IP_WIDTH+1 bits, so wrap-around at the maximum IP
//   is detected as out of range, never silently wrapped.
//  start while running: ignored. exec_done outside ISSUE: ignored.
//  cmp_eq is ignored for every opcode except OP_BEQ.
//  Reset mid-instruction: immediate return to IDLE, with no retire and no handshake.
//  instr_valid deasserts in the cycle after the accepting exec_done.
// STRUCTURE
//  Opcode constants (OP_ADD=8'h00, OP_ADDI=8'h02, OP_SET=8'h03, OP_JMP=8'h40,
//  OP_BEQ=8'h50) and HALT_WORD go in params.svh. The state enum typedef
//  (IDLE/FETCH/ISSUE/HALT) also goes there so datapath and bench can share it.
//  Single module: state register, IP register, instr register, retire counter,
//  and a combinational next-IP block. No sub-module is needed.
// TESTING
//  1. nrst=0 then release, no start -> IDLE, ip=0, mem_en=0, instr_valid=0, retired=0.
//  2. Multiply program (0x03000000,0x03010000,0x03020600,0x03030500,0x50080102,
//     0x00000003,0x02010101,0x40040000, HALT at line 8). Datapath model acks with
//     exec_done on the same cycle and sets cmp_eq=1 on the 7th beq
//     -> halted=1, ip=8, retired=29, fault=0.
//  3. Jump 0x40FF0000 with NUM_LINES=8 -> fault=1, halted=1, ip holds the jump's own IP.
//  4. Hold exec_done low for 5 cycles in ISSUE -> instr and ip stable, instr_valid
//     high throughout, retired unchanged until ack.
//  5. Pulse nrst low while in ISSUE -> next cycle IDLE, instr_valid=0, ip=0;
//     a new start re-runs from line 0.
//  6. beq with cmp_eq=0 -> ip advances by 1. start pulse during ISSUE -> no effect.
//     start in HALT after a fault -> fault cleared, fetch resumes at ip=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the instruction sequencer: widths, opcodes, halt word and
// the sequencer state encoding used by the datapath and the bench.
package fetch_sequencer_pkg;

    localparam int FS_IP_WIDTH   = 8;
    localparam int FS_LINE_WIDTH = 32;
    localparam int FS_NUM_LINES  = 8;

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_ADDI = 8'h02;
    localparam logic [7:0] OP_SET  = 8'h03;
    localparam logic [7:0] OP_JMP  = 8'h40;
    localparam logic [7:0] OP_BEQ  = 8'h50;

    localparam logic [FS_LINE_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction sequencer: owns the IP, fetches a line per instruction, issues it
// with a valid/done handshake and resolves the next IP (sequential, jmp, beq).
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int IP_WIDTH   = FS_IP_WIDTH,
    parameter int LINE_WIDTH = FS_LINE_WIDTH,
    parameter int NUM_LINES  = FS_NUM_LINES,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    output logic                  mem_en,
    output logic [IP_WIDTH-1:0]   ip,
    input  logic [LINE_WIDTH-1:0] line,
    output logic [LINE_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  exec_done,
    input  logic                  cmp_eq,
    output logic                  running,
    output logic                  halted,
    output logic                  fault,
    output logic [CNT_WIDTH-1:0]  retired
);

    // Next IP is one bit wider than both the IP and the 8-bit target field, so a
    // wrap past the top IP or a wide jump target shows up as out of range.
    localparam int NIW = ((IP_WIDTH > 8) ? IP_WIDTH : 8) + 1;

    seq_state_e              state_q, state_d;
    logic [IP_WIDTH-1:0]     ip_q, ip_d;
    logic [LINE_WIDTH-1:0]   instr_q, instr_d;
    logic                    fault_q, fault_d;
    logic [CNT_WIDTH-1:0]    retired_q, retired_d;

    logic [7:0]              op;
    logic [7:0]              tgt;
    logic [NIW-1:0]          next_ip;

    assign op  = instr_q[LINE_WIDTH-1 -: 8];
    assign tgt = instr_q[LINE_WIDTH-9 -: 8];

    always_comb begin
        next_ip = NIW'(ip_q) + NIW'(1);
        if (op == OP_JMP || (op == OP_BEQ && cmp_eq)) begin
            next_ip = NIW'(tgt);
        end
    end

    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        instr_d   = instr_q;
        fault_d   = fault_q;
        retired_d = retired_q;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d   = FETCH;
                    ip_d      = '0;
                    fault_d   = 1'b0;
                    retired_d = '0;
                end
            end
            FETCH: begin
                if (line == HALT_WORD) begin
                    state_d = HALT;
                end else begin
                    instr_d = line;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (exec_done) begin
                    if (retired_q != {CNT_WIDTH{1'b1}}) begin
                        retired_d = retired_q + CNT_WIDTH'(1);
                    end
                    // Out-of-range target: stop with ip left on the faulting instruction.
                    if (next_ip > NIW'(NUM_LINES)) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        ip_d    = next_ip[IP_WIDTH-1:0];
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            ip_q      <= '0;
            instr_q   <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ip_q      <= ip_d;
            instr_q   <= instr_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    assign mem_en      = (state_q == FETCH);
    assign instr_valid = (state_q == ISSUE);
    assign running     = (state_q == FETCH) || (state_q == ISSUE);
    assign halted      = (state_q == HALT);
    assign ip          = ip_q;
    assign instr       = instr_q;
    assign fault       = fault_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a small line memory and datapath model
// around the DUT, one task per scenario with inline expected-value checks.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        mem_en;
    logic [7:0]  ip;
    logic [31:0] line;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        cmp_eq;
    logic        running;
    logic        halted;
    logic        fault;
    logic [15:0] retired;

    logic        auto_ack = 1'b0;
    logic        exec_done_r = 1'b0;
    logic        cmp_eq_r = 1'b0;
    logic        beq_clr = 1'b1;
    int          beq_cnt;
    logic [31:0] mem [16];

    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .clk(clk), .nrst(nrst), .start(start), .mem_en(mem_en), .ip(ip),
        .line(line), .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .cmp_eq(cmp_eq), .running(running),
        .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    always_comb line = (ip < 8'd16) ? mem[ip[3:0]] : HALT_WORD;

    // Auto-ack datapath: same-cycle exec_done, beq taken on the 7th beq.
    assign exec_done = auto_ack ? 1'b1 : exec_done_r;
    assign cmp_eq    = auto_ack ? ((instr[31:24] == OP_BEQ) && (beq_cnt == 6)) : cmp_eq_r;

    always @(posedge clk) begin
        if (beq_clr) beq_cnt <= 0;
        else if (instr_valid && exec_done && instr[31:24] == OP_BEQ) beq_cnt <= beq_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = HALT_WORD;
    endtask

    task automatic apply_reset();
        nrst = 1'b0;
        auto_ack = 1'b0;
        exec_done_r = 1'b0;
        cmp_eq_r = 1'b0;
        start = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_halt(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (halted) break;
            tick();
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, budget);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
        tick();
        tick();
        checks++; if (ip !== 8'd0) begin errors++; $display("FAIL reset_ip: got %0d want 0", ip); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
        checks++; if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if ({running, halted, fault} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {running, halted, fault}); end
    endtask

    task automatic test_multiply();
        apply_reset();
        clear_mem();
        mem[0] = 32'h03000000; mem[1] = 32'h03010000; mem[2] = 32'h03020600;
        mem[3] = 32'h03030500; mem[4] = 32'h50080102; mem[5] = 32'h00000003;
        mem[6] = 32'h02010101; mem[7] = 32'h40040000; mem[8] = HALT_WORD;
        beq_clr = 1'b1;
        tick();
        beq_clr = 1'b0;
        auto_ack = 1'b1;
        do_start();
        checks++; if ({mem_en, instr_valid} !== 2'b10) begin errors++; $display("FAIL mul_fetch1: mem_en,valid=%b want 10", {mem_en, instr_valid}); end
        tick();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL mul_latency: valid=%b want 1", instr_valid); end
        checks++; if (instr !== 32'h03000000) begin errors++; $display("FAIL mul_first_instr: got %h want 03000000", instr); end
        run_to_halt(200);
        checks++; if (ip !== 8'd8) begin errors++; $display("FAIL mul_ip: got %0d want 8", ip); end
        checks++; if (retired !== 16'd29) begin errors++; $display("FAIL mul_retired: got %0d want 29", retired); end
        checks++; if ({running, fault} !== 2'b00) begin errors++; $display("FAIL mul_flags: running,fault=%b want 00", {running, fault}); end
        auto_ack = 1'b0;
        beq_clr = 1'b1;
    endtask

    task automatic test_fault_jump();
        apply_reset();
        clear_mem();
        mem[0] = 32'h03000000;
        mem[1] = 32'h40FF0000;
        auto_ack = 1'b1;
        do_start();
        run_to_halt(50);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL jmp_fault: got %b want 1", fault); end
        checks++; if (ip !== 8'd1) begin errors++; $display("FAIL jmp_ip: got %0d want 1", ip); end
        checks++; if (retired !== 16'd2) begin errors++; $display("FAIL jmp_retired: got %0d want 2", retired); end
        auto_ack = 1'b0;
        // restart from HALT after the fault
        do_start();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL restart_fault: got %b want 0", fault); end
        checks++; if ({ip, retired} !== 24'd0) begin errors++; $display("FAIL restart_ip_ret: ip=%0d ret=%0d want 0 0", ip, retired); end
        checks++; if ({mem_en, running, halted} !== 3'b110) begin errors++; $display("FAIL restart_state: got %b want 110", {mem_en, running, halted}); end
        tick();
        checks++; if (instr !== 32'h03000000 || instr_valid !== 1'b1) begin errors++; $display("FAIL restart_issue: instr=%h valid=%b want 03000000 1", instr, instr_valid); end
    endtask

    task automatic test_stall();
        apply_reset();
        clear_mem();
        mem[0] = 32'h03020600;
        do_start();
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h03020600 || ip !== 8'd0 || retired !== 16'd0) begin
                errors++;
                $display("FAIL stall_c%0d: valid=%b instr=%h ip=%0d ret=%0d want 1 03020600 0 0", c, instr_valid, instr, ip, retired);
            end
            tick();
        end
        exec_done_r = 1'b1;
        tick();
        exec_done_r = 1'b0;
        checks++; if (instr_valid !== 1'b0 || retired !== 16'd1 || ip !== 8'd1) begin errors++; $display("FAIL stall_ack: valid=%b ret=%0d ip=%0d want 0 1 1", instr_valid, retired, ip); end
        tick();
        checks++; if (halted !== 1'b1 || ip !== 8'd1 || fault !== 1'b0) begin errors++; $display("FAIL stall_halt: halted=%b ip=%0d fault=%b want 1 1 0", halted, ip, fault); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        clear_mem();
        mem[0] = 32'h03000000;
        mem[1] = 32'h00000003;
        do_start();
        tick();
        exec_done_r = 1'b1;
        tick();
        exec_done_r = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b1 || ip !== 8'd1 || retired !== 16'd1) begin errors++; $display("FAIL mid_pre: valid=%b ip=%0d ret=%0d want 1 1 1", instr_valid, ip, retired); end
        nrst = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || ip !== 8'd0 || retired !== 16'd0 || running !== 1'b0) begin errors++; $display("FAIL mid_reset: valid=%b ip=%0d ret=%0d run=%b want 0 0 0 0", instr_valid, ip, retired, running); end
        tick();
        nrst = 1'b1;
        tick();
        checks++; if (mem_en !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL mid_idle: mem_en=%b run=%b want 0 0", mem_en, running); end
        do_start();
        tick();
        checks++; if (instr_valid !== 1'b1 || ip !== 8'd0 || instr !== 32'h03000000) begin errors++; $display("FAIL mid_rerun: valid=%b ip=%0d instr=%h want 1 0 03000000", instr_valid, ip, instr); end
    endtask

    task automatic test_beq_not_taken();
        apply_reset();
        clear_mem();
        mem[0] = 32'h50080102;
        mem[1] = 32'h00000003;
        do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (instr_valid !== 1'b1 || ip !== 8'd0 || mem_en !== 1'b0) begin errors++; $display("FAIL start_in_issue: valid=%b ip=%0d mem_en=%b want 1 0 0", instr_valid, ip, mem_en); end
        cmp_eq_r = 1'b0;
        exec_done_r = 1'b1;
        tick();
        exec_done_r = 1'b0;
        checks++; if (ip !== 8'd1 || mem_en !== 1'b1) begin errors++; $display("FAIL beq_not_taken: ip=%0d mem_en=%b want 1 1", ip, mem_en); end
        tick();
        cmp_eq_r = 1'b1;
        exec_done_r = 1'b1;
        tick();
        exec_done_r = 1'b0;
        cmp_eq_r = 1'b0;
        checks++; if (ip !== 8'd2) begin errors++; $display("FAIL cmp_eq_ignored_add: ip=%0d want 2", ip); end
        tick();
        checks++; if (halted !== 1'b1 || retired !== 16'd2) begin errors++; $display("FAIL beq_end: halted=%b ret=%0d want 1 2", halted, retired); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_multiply();
        test_fault_jump();
        test_stall();
        test_reset_mid();
        test_beq_not_taken();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
